// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_ctrl                                                 |
// | Purpose  : CPU-side bus master for the MOV/MOC byte RAM. It latches one    |
// |            load/store, runs the four-phase handshake and returns extended  |
// |            read data. Optional macro MEM_ALIGN_CHECK_EN rejects misaligned |
// |            halfword/word accesses before the RAM is strobed.               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        rw,
    input  logic [1:0]  size,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic        sign_ext,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_MOV,
    output logic        mem_R_W,
    output logic [1:0]  mem_size,
    output logic [7:0]  mem_Address,
    output logic [31:0] mem_DataIn,
    input  logic [31:0] mem_DataOut,
    input  logic        mem_MOC
);

    localparam int unsigned         c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_SETUP   = 3'd1;
    localparam logic [2:0] c_ACCESS  = 3'd2;
    localparam logic [2:0] c_RELEASE = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mov;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic               r_rw;
    logic [1:0]         r_size;
    logic [7:0]         r_addr;
    logic [31:0]        r_wdata;
    logic               r_sext;
    logic               r_abort;

    logic [2:0]         w_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_mov_next;
    logic               w_err_next;
    logic               w_accept;
    logic               w_capture;
    logic               w_abort;
    logic [31:0]        w_rdata_ext;

    // Requests that must never reach the RAM are flagged at acceptance.
    always_comb begin
        w_abort = (size == 2'b11);
`ifdef MEM_ALIGN_CHECK_EN
        if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) begin
            w_abort = 1'b1;
        end
`endif
    end

    always_comb begin
        case (r_size)
            2'b00:   w_rdata_ext = {{24{r_sext & mem_DataOut[7]}},  mem_DataOut[7:0]};
            2'b01:   w_rdata_ext = {{16{r_sext & mem_DataOut[15]}}, mem_DataOut[15:0]};
            default: w_rdata_ext = mem_DataOut;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_mov_next = r_mov;
        w_err_next = 1'b0;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    w_next   = c_SETUP;
                end
            end
            // Aborted requests still spend this cycle, so done lands one edge after acceptance.
            c_SETUP: begin
                w_cnt_next = '0;
                if (r_abort) begin
                    w_err_next = 1'b1;
                    w_next     = c_DONE;
                end else begin
                    w_mov_next = 1'b1;
                    w_next     = c_ACCESS;
                end
            end
            c_ACCESS: begin
                if (r_cnt == c_CNT_MAX) begin
                    w_mov_next = 1'b0;
                    w_err_next = 1'b1;
                    w_next     = c_DONE;
                end else if (mem_MOC) begin
                    w_capture  = r_rw;
                    w_mov_next = 1'b0;
                    w_next     = c_RELEASE;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            c_RELEASE: begin
                if (r_cnt == c_CNT_MAX) begin
                    w_err_next = 1'b1;
                    w_next     = c_DONE;
                end else if (!mem_MOC) begin
                    w_cnt_next = '0;
                    w_next     = c_DONE;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_mov   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_rw    <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_sext  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_mov   <= w_mov_next;
            r_busy  <= (w_next != c_IDLE);
            r_done  <= (w_next == c_DONE);
            r_err   <= w_err_next;
            if (w_accept) begin
                r_rw    <= rw;
                r_size  <= size;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_sext  <= sign_ext;
                r_abort <= w_abort;
            end
            if (w_capture) begin
                r_rdata <= w_rdata_ext;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign rdata       = r_rdata;
    assign mem_MOV     = r_mov;
    assign mem_R_W     = r_rw;
    assign mem_size    = r_size;
    assign mem_Address = r_addr;
    assign mem_DataIn  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_access_ctrl                                              |
// | Purpose  : Bench for mem_access_ctrl with a MOV/MOC RAM model and a byte-  |
// |            array reference of memory contents and access outcomes.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req;
    logic        rw;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        sign_ext;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_MOV;
    logic        mem_R_W;
    logic [1:0]  mem_size;
    logic [7:0]  mem_Address;
    logic [31:0] mem_DataIn;
    logic [31:0] mem_DataOut;
    logic        mem_MOC;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram     [256];
    logic [7:0]  ref_mem [256];
    logic        ram_init;
    int          moc_delay;
    int          mov_cnt = 0;
    logic        wrote = 1'b0;
    logic        prev_mov = 1'b0;
    int          mov_pulses = 0;
    logic [31:0] model_rdata;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .rw(rw), .size(size), .addr(addr),
        .wdata(wdata), .sign_ext(sign_ext), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_MOV(mem_MOV), .mem_R_W(mem_R_W), .mem_size(mem_size),
        .mem_Address(mem_Address), .mem_DataIn(mem_DataIn),
        .mem_DataOut(mem_DataOut), .mem_MOC(mem_MOC)
    );

    always #5 Clk = ~Clk;

    // RAM model: MOC rises moc_delay cycles after MOV and falls with MOV.
    assign mem_MOC = mem_MOV && (mov_cnt >= moc_delay);

    always_comb begin
        case (mem_size)
            2'b00:   mem_DataOut = {24'h0, ram[mem_Address]};
            2'b01:   mem_DataOut = {16'h0, ram[mem_Address], ram[8'(mem_Address + 8'd1)]};
            default: mem_DataOut = {ram[mem_Address], ram[8'(mem_Address + 8'd1)],
                                    ram[8'(mem_Address + 8'd2)], ram[8'(mem_Address + 8'd3)]};
        endcase
    end

    always @(posedge Clk) begin
        prev_mov <= mem_MOV;
        if (mem_MOV && !prev_mov) mov_pulses <= mov_pulses + 1;
        if (!mem_MOV) begin
            mov_cnt <= 0;
            wrote   <= 1'b0;
        end else if (mov_cnt < 1000000) begin
            mov_cnt <= mov_cnt + 1;
        end
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];
        end else if (mem_MOV && mem_MOC && !mem_R_W && !wrote) begin
            wrote <= 1'b1;
            case (mem_size)
                2'b00: ram[mem_Address] <= mem_DataIn[7:0];
                2'b01: begin
                    ram[mem_Address]               <= mem_DataIn[15:8];
                    ram[8'(mem_Address + 8'd1)]    <= mem_DataIn[7:0];
                end
                default: begin
                    ram[mem_Address]               <= mem_DataIn[31:24];
                    ram[8'(mem_Address + 8'd1)]    <= mem_DataIn[23:16];
                    ram[8'(mem_Address + 8'd2)]    <= mem_DataIn[15:8];
                    ram[8'(mem_Address + 8'd3)]    <= mem_DataIn[7:0];
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    // Big-endian load as a number, then sign-fold by subtracting 2^bits.
    function automatic logic [31:0] ref_load(input logic [1:0] s, input logic [7:0] a, input logic sx);
        longint acc = 0;
        int n = nbytes(s);
        for (int i = 0; i < n; i++) acc = acc * 256 + longint'(ref_mem[(int'(a) + i) % 256]);
        if (sx && n < 4 && acc >= (longint'(1) << (8 * n - 1))) acc = acc - (longint'(1) << (8 * n));
        return 32'(acc);
    endfunction

    task automatic ref_store(input logic [1:0] s, input logic [7:0] a, input logic [31:0] wd);
        int n = nbytes(s);
        for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 256] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
    endtask

    task automatic do_access(input logic r, input logic [1:0] s, input logic [7:0] a,
                             input logic [31:0] wd, input logic sx, input int d, input bit hold);
        bit          illegal;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          pulses0;
        int          k;
        illegal = (s == 2'b11);
`ifdef MEM_ALIGN_CHECK_EN
        if ((s == 2'b01 && (a % 2) != 0) || (s == 2'b10 && (a % 4) != 0)) illegal = 1'b1;
`endif
        exp_rdata = model_rdata;
        if (illegal) begin
            exp_lat = 1;
            exp_err = 1'b1;
        end else if (d >= TIMEOUT) begin
            exp_lat = TIMEOUT + 2;
            exp_err = 1'b1;
        end else begin
            exp_lat = 3 + d;
            exp_err = 1'b0;
            if (r) exp_rdata = ref_load(s, a, sx);
            else   ref_store(s, a, wd);
        end
        moc_delay = d;
        @(negedge Clk);
        req = 1'b1; rw = r; size = s; addr = a; wdata = wd; sign_ext = sx;
        pulses0 = mov_pulses;
        @(posedge Clk); #1;
        check("busy_after_accept", 32'(busy), 32'd1);
        if (!hold) req = 1'b0;
        rw = 1'($urandom); size = 2'($urandom); addr = 8'($urandom);
        wdata = $urandom; sign_ext = 1'($urandom);
        k = 0;
        while (!done && k < 100) begin
            @(posedge Clk); #1;
            k++;
        end
        req = 1'b0;
        check("done_latency", 32'(k), 32'(exp_lat));
        check("err", 32'(err), 32'(exp_err));
        check("rdata", rdata, exp_rdata);
        check("mov_pulses", 32'(mov_pulses - pulses0), illegal ? 32'd0 : 32'd1);
        check("mem_Address", 32'(mem_Address), 32'(a));
        check("mem_size", 32'(mem_size), 32'(s));
        check("mem_R_W", 32'(mem_R_W), 32'(r));
        check("mem_DataIn", mem_DataIn, wd);
        model_rdata = exp_rdata;
        @(posedge Clk); #1;
        check("idle_after_done", {28'h0, busy, done, err, mem_MOV}, 32'h0);
    endtask

    initial begin
        Reset = 1'b1; ram_init = 1'b1; req = 1'b0; rw = 1'b0; size = 2'b00;
        addr = 8'h00; wdata = 32'h0; sign_ext = 1'b0; moc_delay = 0; model_rdata = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'h04] = 8'h12; ref_mem[8'h05] = 8'h34; ref_mem[8'h06] = 8'h56; ref_mem[8'h07] = 8'h78;
        ref_mem[8'h10] = 8'hF0; ref_mem[8'h30] = 8'h80; ref_mem[8'h31] = 8'h01;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_outputs", {26'h0, busy, done, err, mem_MOV, mem_R_W, 1'b0}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_bus", {14'h0, mem_size, mem_Address, 8'h0}, 32'h0);
        check("rst_mem_DataIn", mem_DataIn, 32'h0);
        @(negedge Clk);
        Reset = 1'b0; ram_init = 1'b0;

        do_access(1'b1, 2'b10, 8'h04, 32'h0, 1'b0, 0, 1'b0);
        check("word_load_const", rdata, 32'h12345678);
        do_access(1'b1, 2'b00, 8'h10, 32'h0, 1'b1, 0, 1'b0);
        check("byte_sext_const", rdata, 32'hFFFFFFF0);
        do_access(1'b1, 2'b00, 8'h10, 32'h0, 1'b0, 0, 1'b1);
        check("byte_zext_const", rdata, 32'h000000F0);
        do_access(1'b1, 2'b01, 8'h30, 32'h0, 1'b1, 0, 1'b0);
        check("half_sext_const", rdata, 32'hFFFF8001);
        do_access(1'b0, 2'b10, 8'h20, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        check("store_keeps_rdata", rdata, 32'hFFFF8001);
        do_access(1'b1, 2'b10, 8'h20, 32'h0, 1'b0, 0, 1'b0);
        check("store_then_load", rdata, 32'hDEADBEEF);
        do_access(1'b1, 2'b10, 8'h04, 32'h0, 1'b0, 3, 1'b0);
        do_access(1'b1, 2'b10, 8'h04, 32'h0, 1'b0, 1000, 1'b1);
        do_access(1'b1, 2'b00, 8'h10, 32'h0, 1'b1, TIMEOUT - 1, 1'b0);
        do_access(1'b0, 2'b01, 8'h50, 32'h0000A5A5, 1'b0, TIMEOUT, 1'b0);
        do_access(1'b1, 2'b11, 8'h04, 32'h0, 1'b0, 0, 1'b0);
        do_access(1'b1, 2'b10, 8'h02, 32'h0, 1'b0, 0, 1'b0);
        do_access(1'b1, 2'b10, 8'hFE, 32'h0, 1'b0, 0, 1'b0);

        // Reset while the controller sits in ACCESS.
        moc_delay = 1000;
        @(negedge Clk);
        req = 1'b1; rw = 1'b1; size = 2'b10; addr = 8'h40; sign_ext = 1'b0;
        @(posedge Clk); #1;
        req = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("midrst_outputs", {26'h0, busy, done, err, mem_MOV, mem_R_W, 1'b0}, 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_mem_bus", {14'h0, mem_size, mem_Address, 8'h0}, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        model_rdata = 32'h0;
        @(posedge Clk); #1;
        check("midrst_no_done", {30'h0, done, busy}, 32'h0);
        do_access(1'b1, 2'b01, 8'h30, 32'h0, 1'b0, 0, 1'b0);

        for (int it = 0; it < 150; it++) begin
            logic [1:0] s;
            int         d;
            s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                            : $urandom_range(0, 6);
            do_access(1'($urandom), s, 8'($urandom), $urandom, 1'($urandom), d, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
